// File: rtl/maxpool_window_reader_pkg.sv
// rtl/maxpool_window_reader_pkg.sv - shared constants for the maxpool window reader
// Purpose: FSM state encoding, result/address widths and the unsigned max helper
//          used by the window reader and its address generator.
// Ports: none (package).
package maxpool_window_reader_pkg;

   localparam int RES_W  = 8;
   localparam int ADDR_W = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic logic [RES_W-1:0] max_u(input logic [RES_W-1:0] a,
                                              input logic [RES_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// rtl/maxpool_addr_gen.sv - RAM address of one element of a 2x2 stride-2 window
// Purpose: combinational address for output position (orow, ocol) and window
//          element k (bit1 = bottom row, bit0 = right column).
// Ports:
//   orow, ocol  output-map row/column
//   k           element select: 0 TL, 1 TR, 2 BL, 3 BR
//   addr        BASE_ADDR + (2*orow+k[1])*W + 2*ocol+k[0]
module maxpool_addr_gen
   import maxpool_window_reader_pkg::*;
#(
   parameter int               RW        = 2,
   parameter int               CW        = 2,
   parameter int               W         = 6,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic [RW-1:0]     orow,
   input  logic [CW-1:0]     ocol,
   input  logic [1:0]        k,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] row;
   logic [ADDR_W-1:0] col;

   assign row  = (ADDR_W'(orow) << 1) | ADDR_W'(k[1]);
   assign col  = (ADDR_W'(ocol) << 1) | ADDR_W'(k[0]);
   assign addr = BASE_ADDR + row * ADDR_W'(W) + col;

endmodule

// File: rtl/maxpool_window_reader.sv
// rtl/maxpool_window_reader.sv - 2x2 stride-2 max pooling reader feeding a result stream
// Purpose: walks the H x W map window by window (row-major over outputs), reads the
//          four elements from a synchronous RAM and offers each max on valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, busy, done   pass control and status
//   ram_en, ram_addr    RAM read request (ram_we tied low), ram_rd data one cycle later
//   ans, valid, ready   pooled result handshake toward the writer
module maxpool_window_reader
   import maxpool_window_reader_pkg::*;
#(
   parameter int               H         = 6,
   parameter int               W         = 6,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   input  logic [RES_W-1:0]  ram_rd,
   output logic [RES_W-1:0]  ans,
   output logic              valid,
   input  logic              ready
);

   localparam int ORW = (H / 2 > 1) ? $clog2(H / 2) : 1;
   localparam int OCW = (W / 2 > 1) ? $clog2(W / 2) : 1;

   logic [1:0]        state;
   logic [ORW-1:0]    orow;
   logic [OCW-1:0]    ocol;
   logic [2:0]        k;
   logic [RES_W-1:0]  max_reg;
   logic [ADDR_W-1:0] gen_addr;
   logic [ADDR_W-1:0] addr_q;
   logic              issue;
   logic              last_col;
   logic              last_win;

   maxpool_addr_gen #(
      .RW        (ORW),
      .CW        (OCW),
      .W         (W),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_gen (
      .orow (orow),
      .ocol (ocol),
      .k    (k[1:0]),
      .addr (gen_addr)
   );

   assign issue    = (state == ST_FETCH) && (k < 3'd4);
   assign ram_en   = issue;
   // addr_q remembers the last issued address so the bus is quiet between reads.
   assign ram_addr = issue ? gen_addr : addr_q;
   assign ram_we   = 1'b0;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);
   assign last_col = (ocol == OCW'(W / 2 - 1));
   assign last_win = last_col && (orow == ORW'(H / 2 - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         orow    <= '0;
         ocol    <= '0;
         k       <= '0;
         max_reg <= '0;
         addr_q  <= BASE_ADDR;
         ans     <= '0;
         valid   <= 1'b0;
      end else begin
         if (issue) begin
            addr_q <= gen_addr;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  orow  <= '0;
                  ocol  <= '0;
                  k     <= '0;
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // ram_rd at step k carries the element requested at step k-1.
               if (k == 3'd1) begin
                  max_reg <= ram_rd;
               end else if (k != 3'd0) begin
                  max_reg <= max_u(max_reg, ram_rd);
               end
               if (k == 3'd4) begin
                  ans   <= max_u(max_reg, ram_rd);
                  valid <= 1'b1;
                  state <= ST_OUT;
               end else begin
                  k <= k + 3'd1;
               end
            end
            ST_OUT: begin
               if (ready) begin
                  valid <= 1'b0;
                  if (last_win) begin
                     state <= ST_DONE;
                  end else begin
                     k     <= '0;
                     state <= ST_FETCH;
                     if (last_col) begin
                        ocol <= '0;
                        orow <= orow + 1'b1;
                     end else begin
                        ocol <= ocol + 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool_window_reader.sv
// tb/tb_maxpool_window_reader.sv - self-checking bench for maxpool_window_reader
module tb_maxpool_window_reader;

   localparam int          H     = 6;
   localparam int          W     = 6;
   localparam logic [31:0] BASE  = 32'd0;
   localparam int          H2    = 4;
   localparam int          W2    = 4;
   localparam logic [31:0] BASE2 = 32'd100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   logic        rst, start, busy, done, ram_en, ram_we, valid, ready;
   logic [31:0] ram_addr;
   logic [7:0]  ram_rd, ans;
   logic        rst2, start2, busy2, done2, ram_en2, ram_we2, valid2, ready2;
   logic [31:0] ram_addr2;
   logic [7:0]  ram_rd2, ans2;

   logic [7:0]  mem  [H*W];
   logic [7:0]  mem2 [H2*W2];

   int          ready_mode = 0;
   logic        ready_manual = 1'b0;
   logic        ready_rnd = 1'b1;

   int          got_ans[$];
   logic [31:0] got_addr[$];
   int          exp_ans[$];
   logic [31:0] exp_addr[$];
   int          n_done = 0;
   int          got_ans2[$];
   logic [31:0] got_addr2[$];
   int          n_done2 = 0;

   maxpool_window_reader #(.H(H), .W(W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we), .ram_rd(ram_rd),
      .ans(ans), .valid(valid), .ready(ready)
   );

   maxpool_window_reader #(.H(H2), .W(W2), .BASE_ADDR(BASE2)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
      .ram_en(ram_en2), .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_rd(ram_rd2),
      .ans(ans2), .valid(valid2), .ready(ready2)
   );

   // Synchronous RAMs: data appears the cycle after the enable.
   always @(posedge clk) begin
      if (ram_en) ram_rd <= mem[int'(ram_addr - BASE)];
      if (ram_en2) ram_rd2 <= mem2[int'(ram_addr2 - BASE2)];
   end

   assign ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ready_rnd : ready_manual;

   initial forever begin
      @(posedge clk);
      #1 ready_rnd = 1'($urandom_range(0, 1));
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor: record reads and handshakes, and check hold behaviour under backpressure.
   logic       pv = 1'b0;
   logic       pr = 1'b0;
   logic [7:0] pans = '0;
   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (ram_en) got_addr.push_back(ram_addr);
         if (valid && ready) got_ans.push_back(int'(ans));
         if (done) n_done++;
         if (pv && !pr) begin
            check_eq("hold_valid", int'(valid), 1);
            check_eq("hold_ans", int'(ans), int'(pans));
            check_eq("hold_no_read", int'(ram_en), 0);
         end
         pv = valid;
         pr = ready;
         pans = ans;
      end
      if (!rst2) begin
         if (ram_en2) got_addr2.push_back(ram_addr2);
         if (valid2 && ready2) got_ans2.push_back(int'(ans2));
         if (done2) n_done2++;
      end
   end

   // Reference: each output is the max of its 2x2 block; reads go TL, TR, BL, BR.
   task automatic build_expect();
      exp_ans.delete();
      exp_addr.delete();
      for (int r = 0; r < H / 2; r++) begin
         for (int c = 0; c < W / 2; c++) begin
            int m;
            m = 0;
            for (int d = 0; d < 4; d++) begin
               int idx;
               idx = (2 * r + d / 2) * W + 2 * c + d % 2;
               exp_addr.push_back(BASE + 32'(idx));
               if (int'(mem[idx]) > m) m = int'(mem[idx]);
            end
            exp_ans.push_back(m);
         end
      end
   endtask

   task automatic run_pass(input string tag, input int mode, input bit extra);
      bit seen;
      int bad;
      build_expect();
      got_ans.delete();
      got_addr.delete();
      n_done = 0;
      ready_manual = 1'b0;
      ready_mode = mode;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check_eq({tag, ":busy_on"}, int'(busy), 1);
      repeat (4) @(posedge clk);
      #1 check_eq({tag, ":lat_lo"}, int'(valid), 0);
      @(posedge clk);
      #1 check_eq({tag, ":lat_hi"}, int'(valid), 1);
      if (mode == 2) begin
         logic [7:0] held;
         held = ans;
         check_eq({tag, ":bp_first"}, int'(held), exp_ans[0]);
         repeat (3) begin
            @(posedge clk); #1;
            check_eq({tag, ":bp_valid"}, int'(valid), 1);
            check_eq({tag, ":bp_ans"}, int'(ans), int'(held));
            check_eq({tag, ":bp_noread"}, int'(ram_en), 0);
         end
         ready_manual = 1'b1;
         @(posedge clk); #1;
         check_eq({tag, ":bp_drop"}, int'(valid), 0);
         check_eq({tag, ":bp_fetch_en"}, int'(ram_en), 1);
         check_eq({tag, ":bp_fetch_addr"}, int'(ram_addr), int'(exp_addr[4]));
         ready_mode = 0;
      end
      if (extra) begin
         repeat (3) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         check_eq({tag, ":busy_mid"}, int'(busy), 1);
      end
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq({tag, ":done_seen"}, int'(seen), 1);
      if (extra) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check_eq({tag, ":busy_off"}, int'(busy), 0);
      repeat (3) @(posedge clk);
      #1 check_eq({tag, ":stay_idle"}, int'(busy), 0);
      check_eq({tag, ":n_res"}, got_ans.size(), exp_ans.size());
      bad = 0;
      for (int i = 0; i < got_ans.size() && i < exp_ans.size(); i++)
         if (got_ans[i] != exp_ans[i]) bad++;
      check_eq({tag, ":ans_seq_bad"}, bad, 0);
      check_eq({tag, ":n_addr"}, got_addr.size(), exp_addr.size());
      bad = 0;
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
         if (got_addr[i] !== exp_addr[i]) bad++;
      check_eq({tag, ":addr_seq_bad"}, bad, 0);
      check_eq({tag, ":n_done"}, n_done, 1);
   endtask

   initial begin
      int ramp_exp[9];
      int bad;
      bit seen;
      ramp_exp = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
      rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; ready2 = 1'b1;
      for (int i = 0; i < H * W; i++) mem[i] = 8'(i);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rst2 = 1'b0;
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_ram_en", int'(ram_en), 0);
      check_eq("rst_ram_addr", int'(ram_addr), int'(BASE));
      check_eq("rst_ans", int'(ans), 0);
      check_eq("rst_valid", int'(valid), 0);
      check_eq("rst_ram_we", int'(ram_we), 0);
      check_eq("rst2_ram_addr", int'(ram_addr2), int'(BASE2));

      run_pass("ramp", 0, 1'b0);
      bad = 0;
      for (int i = 0; i < 9 && i < got_ans.size(); i++)
         if (got_ans[i] != ramp_exp[i]) bad++;
      check_eq("ramp_const_bad", bad, 0);

      for (int i = 0; i < H * W; i++) mem[i] = 8'd0;
      mem[0] = 8'd200; mem[3] = 8'd200; mem[10] = 8'd200; mem[19] = 8'd200;
      mem[14] = 8'd254; mem[21] = 8'd255; mem[16] = 8'd255; mem[17] = 8'd254;
      run_pass("maxpos", 1, 1'b0);
      if (got_ans.size() >= 6) begin
         check_eq("maxpos_tl", got_ans[0], 200);
         check_eq("maxpos_tr", got_ans[1], 200);
         check_eq("maxpos_bl", got_ans[2], 200);
         check_eq("maxpos_br", got_ans[3], 200);
         check_eq("tie_a", got_ans[4], 255);
         check_eq("tie_b", got_ans[5], 255);
      end else begin
         check_eq("maxpos_size", got_ans.size(), 9);
      end

      for (int i = 0; i < H * W; i++) mem[i] = 8'($urandom);
      run_pass("backpressure", 2, 1'b0);

      for (int i = 0; i < H * W; i++) mem[i] = 8'($urandom);
      run_pass("start_busy", 1, 1'b1);

      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < H * W; i++) mem[i] = 8'($urandom);
         run_pass("random", 1, 1'b0);
      end

      // Reset during the fetch of window 4.
      got_ans.delete();
      ready_mode = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (got_ans.size() >= 4 && ram_en) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("mid_reach_win4", int'(seen), 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check_eq("mid_rst_valid", int'(valid), 0);
      check_eq("mid_rst_busy", int'(busy), 0);
      check_eq("mid_rst_ram_en", int'(ram_en), 0);
      check_eq("mid_rst_ram_addr", int'(ram_addr), int'(BASE));
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (valid || busy) seen = 1'b1;
      end
      check_eq("mid_rst_quiet", int'(seen), 0);
      for (int i = 0; i < H * W; i++) mem[i] = 8'($urandom);
      run_pass("after_rst", 0, 1'b0);

      // 4x4 map at base 100.
      for (int i = 0; i < H2 * W2; i++) mem2[i] = 8'($urandom);
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #1;
         if (done2) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("b100_done_seen", int'(seen), 1);
      repeat (3) @(posedge clk);
      #1 check_eq("b100_busy_off", int'(busy2), 0);
      check_eq("b100_n_addr", got_addr2.size(), 16);
      if (got_addr2.size() >= 4) begin
         check_eq("b100_addr0", int'(got_addr2[0]), 100);
         check_eq("b100_addr1", int'(got_addr2[1]), 101);
         check_eq("b100_addr2", int'(got_addr2[2]), 104);
         check_eq("b100_addr3", int'(got_addr2[3]), 105);
      end
      bad = 0;
      foreach (got_addr2[i])
         if (got_addr2[i] < 32'd100 || got_addr2[i] > 32'd115) bad++;
      check_eq("b100_addr_range_bad", bad, 0);
      check_eq("b100_n_res", got_ans2.size(), 4);
      bad = 0;
      for (int r = 0; r < H2 / 2; r++) begin
         for (int c = 0; c < W2 / 2; c++) begin
            int m;
            int n;
            m = 0;
            for (int d = 0; d < 4; d++)
               if (int'(mem2[(2 * r + d / 2) * W2 + 2 * c + d % 2]) > m)
                  m = int'(mem2[(2 * r + d / 2) * W2 + 2 * c + d % 2]);
            n = r * (W2 / 2) + c;
            if (n >= got_ans2.size() || got_ans2[n] != m) bad++;
         end
      end
      check_eq("b100_ans_bad", bad, 0);
      check_eq("b100_n_done", n_done2, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
